uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance among NUM_REQUESTERS byte sources using round-robin arbitration.
- Each requester presents bytes on a valid/ready handshake.
- The arbiter latches the granted byte, pulses uart_tx start, and waits for the full frame to finish before the next grant.
- Sits between the packet/debug producers and uart_tx; sample_trigger stays wired directly to uart_tx.

Parameters:
- NUM_REQUESTERS, 4: number of requester ports, 2..16.
- ID_WIDTH, $clog2(NUM_REQUESTERS): width of the grant index.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQUESTERS  per-requester byte available.
- req_data  input  8*NUM_REQUESTERS  per-requester byte; requester i uses bits [8i+7:8i].
- req_ready  output  NUM_REQUESTERS  one-hot, 1-cycle pulse; byte of requester i accepted this cycle.
- tx_data  output  8  byte to uart_tx data.
- tx_start  output  1  to uart_tx start.
- tx_ready  input  1  from uart_tx ready; high = idle, low = busy or in reset.
- busy  output  1  high from byte capture until uart_tx returns ready.
- grant_id  output  ID_WIDTH  index of the requester currently owning the transmitter.

Behaviour:
- Reset values: state=IDLE, req_ready=0, tx_start=0, tx_data=0, busy=0, grant_id=0, rr pointer last=NUM_REQUESTERS-1 (so requester 0 has first priority).
- Reset is synchronous; asserting rst mid-frame aborts the sequence and returns to IDLE next edge. uart_tx is reset by the same rst.
- All outputs are registered.
- State IDLE:
  - If tx_ready=1 and any req_valid=1, pick the winner w = first set bit of req_valid searching last+1, last+2, … modulo N.
  - In that cycle's edge: tx_data<=req_data[w], grant_id<=w, req_ready[w]<=1 (one cycle), last<=w, busy<=1, go to START.
  - If tx_ready=0, no grant.
- State START:
  - tx_start=1; req_ready cleared.
  - Hold tx_start high until tx_ready is sampled 0, then deassert tx_start and go to WAIT_DONE.
  - This guarantees exactly one frame per grant, because uart_tx resends while start remains high.
- State WAIT_DONE:
  - tx_start=0. When tx_ready is sampled 1, set busy<=0 and go to IDLE.
  - The earliest next grant is the following cycle (1 idle cycle between grants).
- Handshake rules:
  - A requester must hold req_valid and req_data stable until its req_ready pulse.
  - Dropping req_valid before grant is allowed; that request is simply not served.
  - req_data is sampled only on the grant edge; later changes do not affect the frame in flight.
- Fairness: with all N requesters continuously valid, grants rotate 0,1,…,N-1,0,…; no requester waits more than N-1 frames.
- Boundaries:
  - Single requester valid: it is granted back-to-back, regardless of pointer.
  - req_valid arriving in the same cycle as another grant waits for the next IDLE.
  - tx_ready low at startup (uart_tx still in reset) blocks grants.
  - tx_data holds its last value while idle.
- Latency: req_valid with idle arbiter → req_ready and tx_data next edge → tx_start one edge later.

Decomposition:
- Package uart_pkg: typedef enum logic [1:0] {IDLE, START, WAIT_DONE} uart_arb_state_t; localparam UART_DATA_WIDTH=8.
- Sub-module rr_picker (combinational): inputs req[N] and last[ID_WIDTH]; outputs found and winner[ID_WIDTH]. It is reusable by future arbiters.

Test Plan:
- Reset held 300 cycles with req_valid=4'b1111 -> req_ready=0, tx_start=0, busy=0 throughout; after release the first grant goes to id 0.
- Single byte: req_valid[2]=1, req_data[2]=8'hD5, arbiter + uart_tx + pulse_generator(INTERVAL=10) -> req_ready[2] pulses once; serial stream is start bit, then bits 1,0,1,0,1,0,1,1 (LSB first), then stop bit (16 samples each); busy falls with tx_ready.
- Round robin: all four valid with bytes 8'h11,8'h22,8'h33,8'h44 held -> frames transmitted in order 11,22,33,44,11; grant_id sequence 0,1,2,3,0.
- Exactly-once: requester 1 holds req_valid for 5000 cycles after its req_ready pulse -> it is accepted again only after tx_ready returns; tx_start never stays high once tx_ready=0; frame count equals req_ready pulse count.
- Data stability: change req_data[0] from 8'hA5 to 8'hFF one cycle after grant -> 8'hA5 is transmitted.
- Mid-frame reset: assert rst for 1 cycle during bit 4 of a frame -> next edge state IDLE, busy=0, tx_start=0; the pending requester is re-granted after tx_ready rises.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } uart_arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_tx-side signals of the arbiter.
//
// Handshake: a requester raises req_valid[i] with req_data[8i+7:8i] and holds
// both stable until req_ready[i] pulses for one cycle. That pulse marks the
// edge on which the byte was captured. Dropping req_valid before the pulse
// withdraws the request. tx_ready high means uart_tx is idle; tx_start is held
// until tx_ready is seen low, so exactly one frame is sent per grant.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQUESTERS = 4,
  parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS)
) ();

  logic [NUM_REQUESTERS-1:0]   req_valid;
  logic [8*NUM_REQUESTERS-1:0] req_data;
  logic [NUM_REQUESTERS-1:0]   req_ready;
  logic [7:0]                  tx_data;
  logic                        tx_start;
  logic                        tx_ready;
  logic                        busy;
  logic [ID_WIDTH-1:0]         grant_id;

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, tx_ready,
    output req_ready, tx_data, tx_start, busy, grant_id
  );

  // Producer / uart_tx / environment side.
  modport master (
    output req_valid, req_data, tx_ready,
    input  req_ready, tx_data, tx_start, busy, grant_id
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of req_i searching from
// last_i+1 upward, wrapping modulo N.
module rr_picker #(
  parameter int N        = 4,
  parameter int ID_WIDTH = $clog2(N)
) (
  input  logic [N-1:0]        req_i,
  input  logic [ID_WIDTH-1:0] last_i,
  output logic                found_o,
  output logic [ID_WIDTH-1:0] winner_o
);

  int idx;

  // Scan from farthest to nearest so the nearest set bit after last_i wins.
  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    idx      = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_i) + k) % N;
      if (req_i[idx]) begin
        found_o  = 1'b1;
        winner_o = ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQUESTERS byte sources.
// One byte is captured per grant; the next grant waits until the frame ends.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS)
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  arb,
  output uart_arb_state_t   state_o
);

  uart_arb_state_t             state_q, state_d;
  logic [NUM_REQUESTERS-1:0]   req_ready_q, req_ready_d;
  logic [UART_DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic                        tx_start_q, tx_start_d;
  logic                        busy_q, busy_d;
  logic [ID_WIDTH-1:0]         grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0]         last_q, last_d;

  logic                        found;
  logic [ID_WIDTH-1:0]         winner;

  rr_picker #(
    .N        (NUM_REQUESTERS),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .req_i    (arb.req_valid),
    .last_i   (last_q),
    .found_o  (found),
    .winner_o (winner)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: grant only into an idle uart_tx, leave START once uart_tx has
  // gone busy, and return to IDLE when it is ready again.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (arb.tx_ready && found) state_d = START;
      START:     if (!arb.tx_ready)         state_d = WAIT_DONE;
      WAIT_DONE: if (arb.tx_ready)          state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs. tx_start stays high in START only
  // while uart_tx still reports ready, so it drops the edge after the frame
  // begins and uart_tx never sees a second start.
  always_comb begin
    req_ready_d = '0;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    busy_d      = busy_q;
    grant_id_d  = grant_id_q;
    last_d      = last_q;
    case (state_q)
      IDLE: begin
        if (arb.tx_ready && found) begin
          req_ready_d[winner] = 1'b1;
          tx_data_d  = arb.req_data[UART_DATA_WIDTH*int'(winner) +: UART_DATA_WIDTH];
          grant_id_d = winner;
          last_d     = winner;
          busy_d     = 1'b1;
        end
      end
      START:     tx_start_d = arb.tx_ready;
      WAIT_DONE: if (arb.tx_ready) busy_d = 1'b0;
      default: ;
    endcase
  end

  // Output and pointer registers; last resets to N-1 so requester 0 goes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready_q <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      grant_id_q  <= '0;
      last_q      <= ID_WIDTH'(NUM_REQUESTERS - 1);
    end else begin
      req_ready_q <= req_ready_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      grant_id_q  <= grant_id_d;
      last_q      <= last_d;
    end
  end

  assign arb.req_ready = req_ready_q;
  assign arb.tx_data   = tx_data_q;
  assign arb.tx_start  = tx_start_q;
  assign arb.busy      = busy_q;
  assign arb.grant_id  = grant_id_q;
  assign state_o       = state_q;

endmodule
